ir_blk_sequencer: RTL and testbench
===================================

// Module: ir_blk_sequencer
// PURPOSE
//  Block controller for the interleaver datapath. Decodes (rate_id, subchan_ct) to Ncbps,
//  sequences fill of the block buffer in EX_W-bit words, fires the permutation, then drains it.
//  Sits between the FEC encoder output stream and the interleaver buffer/permute logic.
//  One block in flight; config latched per block.
// PARAMETERS
//  EX_W     12  external word width in bits; must divide 12 (1,2,3,4,6,12)
//  RATE_W   2   rate_id width: 0 BPSK, 1 QPSK, 2 16-QAM, 3 64-QAM
//  SUBCT_W  3   subchan_ct width: code 0..4 = 16,8,4,2,1 subchannels; 5..7 illegal
//  CT_W     11  word counter / address width (holds 1152/EX_W - 1 for EX_W=1)
// PORTS
//  clk          in   1        clock
//  reset        in   1        synchronous, active-high reset
//  rate_id      in   RATE_W   modulation select, sampled only at block start
//  subchan_ct   in   SUBCT_W  subchannel code, sampled only at block start
//  in_valid     in   1        upstream word valid
//  in_ready     out  1        controller accepts a word this cycle
//  wr_en        out  1        write in-word to buffer at wr_addr (= in_valid & in_ready)
//  wr_addr      out  CT_W     buffer word address for current write
//  perm_go      out  1        one-cycle pulse: interleaver permutes filled buffer
//  cfg_rate     out  RATE_W   latched rate_id of current block (drives permute select)
//  cfg_subch    out  SUBCT_W  latched subchan_ct of current block
//  blk_ncbps    out  11       latched Ncbps of current block
//  rd_addr      out  CT_W     buffer word address being presented downstream
//  out_valid    out  1        word at rd_addr valid for downstream
//  out_ready    in   1        downstream accepts word
//  out_last     out  1        rd_addr is final word of block (qualified by out_valid)
//  cfg_err      out  1        illegal config requested at block start
//  busy         out  1        state != IDLE
// BEHAVIOUR
//  Ncbps = base[rate] >> subchan_ct, base = {192,384,768,1152}; words = Ncbps/EX_W (min 1).
//  FSM: IDLE, FILL, PERM, DRAIN. Reset -> IDLE; all outputs and counters 0 except in_ready
//   (combinational, see IDLE). Reset mid-block discards partial block, no perm_go/out_valid.
//  IDLE: in_ready = legal(subchan_ct). cfg_err = in_valid & !legal (level, combinational).
//   On accept: latch cfg_rate/cfg_subch/blk_ncbps/words, wr_addr=0 written, cnt<=1;
//   -> PERM if words==1 else FILL.
//  FILL: in_ready=1; each accept writes wr_addr=cnt, cnt++. Accept with cnt==words-1 -> PERM.
//   in_valid low = bubble, no state change. rate_id/subchan_ct changes ignored.
//  PERM: exactly one cycle, perm_go=1, in_ready=0; cnt<=0; -> DRAIN.
//  DRAIN: in_ready=0, out_valid=1, rd_addr=cnt, out_last=(cnt==words-1).
//   out_ready=1 -> cnt++; out_ready=0 -> rd_addr/out_last hold. Handshake on last -> IDLE.
//  Buffer read is combinational; data for rd_addr valid in same cycle as out_valid.
//  wr_addr/rd_addr are 0 when their state is not active. cnt never exceeds words-1.
//  Block-to-block gap: one IDLE cycle minimum after last drain handshake.
// TESTING
//  reset held 2 cycles, subchan_ct=0 -> busy=0, out_valid=0, perm_go=0, in_ready=1, wr_en=0.
//  rate=1,sub=1,in_valid=1 -> blk_ncbps=192, wr_addr 0..15, perm_go 1 cycle, rd_addr 0..15, out_last @15.
//  rate=0,sub=4 (Ncbps 12, EX_W=12) -> single accept, IDLE->PERM->DRAIN, out_last with first word.
//  DRAIN with out_ready 1,0,0,1 -> rd_addr 0,1,1,1,2; no skip or repeat of handshaken words.
//  subchan_ct=5,in_valid=1 -> cfg_err=1, in_ready=0, wr_en=0, busy=0; sub=2 next -> accepted.
//  rate=3,sub=0, reset at 7th FILL word -> IDLE next cycle; next block starts wr_addr=0, 96 words.

Source files
------------

// File: rtl/ir_blk_sequencer.sv
// ---------------------------------------------------------------------------
// ir_blk_sequencer
//   Block controller for the interleaver datapath. Decodes (rate_id,
//   subchan_ct) into Ncbps and the per-block word count. It then sequences the
//   fill of the block buffer in EX_W-bit words, fires the permutation, and
//   drains the permuted buffer downstream. Only one block is in flight at a
//   time. The configuration is latched when the first word of a block is
//   accepted.
//
// Ports
//   clk, reset    clock, synchronous active-high reset
//   rate_id       modulation select (0 BPSK .. 3 64-QAM), sampled at block start
//   subchan_ct    subchannel code (0..4 legal), sampled at block start
//   in_valid      upstream word valid
//   in_ready      controller accepts an upstream word this cycle
//   wr_en         buffer write strobe (in_valid & in_ready)
//   wr_addr       buffer word address of the current write
//   perm_go       one-cycle pulse that starts the permutation
//   cfg_rate      latched rate_id of the current block
//   cfg_subch     latched subchan_ct of the current block
//   blk_ncbps     latched Ncbps of the current block
//   rd_addr       buffer word address presented downstream
//   out_valid     word at rd_addr is valid
//   out_ready     downstream accepts the word
//   out_last      rd_addr is the final word of the block
//   cfg_err       illegal subchannel code offered at block start
//   busy          controller is not idle
//   dbg_state     current FSM state, for debug and checker binding
//
// Handshake rule (both sides): a word transfers on a cycle where valid and
// ready are both high. On the upstream side, in_ready never depends on
// in_valid. On the downstream side, out_valid and rd_addr hold until out_ready.
// ---------------------------------------------------------------------------
module ir_blk_sequencer #(
  parameter int EX_W    = 12,
  parameter int RATE_W  = 2,
  parameter int SUBCT_W = 3,
  parameter int CT_W    = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [RATE_W-1:0]  rate_id,
  input  logic [SUBCT_W-1:0] subchan_ct,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               wr_en,
  output logic [CT_W-1:0]    wr_addr,
  output logic               perm_go,
  output logic [RATE_W-1:0]  cfg_rate,
  output logic [SUBCT_W-1:0] cfg_subch,
  output logic [10:0]        blk_ncbps,
  output logic [CT_W-1:0]    rd_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               cfg_err,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    PERM  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [10:0] EX_W_L = 11'(EX_W);

  state_e             state_q, state_d;
  logic [CT_W-1:0]    cnt_q, cnt_d;
  logic [CT_W-1:0]    words_q, words_d;
  logic [RATE_W-1:0]  cfg_rate_q, cfg_rate_d;
  logic [SUBCT_W-1:0] cfg_subch_q, cfg_subch_d;
  logic [10:0]        ncbps_q, ncbps_d;

  // Decode of the configuration currently on the inputs. It is only used in
  // IDLE, when the first word of a block is accepted.
  logic [10:0]     base_ncbps;
  logic [10:0]     ncbps_in;
  logic [10:0]     words_div;
  logic [CT_W-1:0] words_in;
  logic            legal;

  always_comb begin
    base_ncbps = 11'd192;
    case (rate_id)
      RATE_W'(1): base_ncbps = 11'd384;
      RATE_W'(2): base_ncbps = 11'd768;
      RATE_W'(3): base_ncbps = 11'd1152;
      default:    base_ncbps = 11'd192;
    endcase
    ncbps_in  = base_ncbps >> subchan_ct;
    words_div = ncbps_in / EX_W_L;
    // A block always occupies at least one buffer word.
    words_in  = (words_div == 11'd0) ? CT_W'(1) : CT_W'(words_div);
    legal     = (subchan_ct <= SUBCT_W'(4));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      words_q     <= '0;
      cfg_rate_q  <= '0;
      cfg_subch_q <= '0;
      ncbps_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      words_q     <= words_d;
      cfg_rate_q  <= cfg_rate_d;
      cfg_subch_q <= cfg_subch_d;
      ncbps_q     <= ncbps_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    words_d     = words_q;
    cfg_rate_d  = cfg_rate_q;
    cfg_subch_d = cfg_subch_q;
    ncbps_d     = ncbps_q;
    in_ready    = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    rd_addr     = '0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    perm_go     = 1'b0;
    cfg_err     = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = legal;
        cfg_err  = in_valid & ~legal;
        wr_en    = in_valid & legal;
        if (wr_en) begin
          // The first word goes to address 0 in this same cycle.
          cfg_rate_d  = rate_id;
          cfg_subch_d = subchan_ct;
          ncbps_d     = ncbps_in;
          words_d     = words_in;
          if (words_in == CT_W'(1)) begin
            // Single-word block: skip FILL. Keeping cnt at 0 holds the
            // invariant cnt <= words-1.
            cnt_d   = '0;
            state_d = PERM;
          end else begin
            cnt_d   = CT_W'(1);
            state_d = FILL;
          end
        end
      end

      FILL: begin
        in_ready = 1'b1;
        wr_en    = in_valid;
        wr_addr  = cnt_q;
        if (in_valid) begin
          if (cnt_q == words_q - CT_W'(1)) begin
            cnt_d   = '0;
            state_d = PERM;
          end else begin
            cnt_d = cnt_q + CT_W'(1);
          end
        end
      end

      PERM: begin
        perm_go = 1'b1;
        cnt_d   = '0;
        state_d = DRAIN;
      end

      DRAIN: begin
        out_valid = 1'b1;
        rd_addr   = cnt_q;
        out_last  = (cnt_q == words_q - CT_W'(1));
        if (out_ready) begin
          if (out_last) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign cfg_rate  = cfg_rate_q;
  assign cfg_subch = cfg_subch_q;
  assign blk_ncbps = ncbps_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ir_blk_sequencer.sv
module tb_ir_blk_sequencer;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rate_id;
  logic [2:0]  subchan_ct;
  logic        in_valid;
  logic        out_ready;
  logic        in_ready, wr_en, perm_go, out_valid, out_last, cfg_err, busy;
  logic [10:0] wr_addr, rd_addr, blk_ncbps;
  logic [1:0]  cfg_rate;
  logic [2:0]  cfg_subch;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  ir_blk_sequencer #(.EX_W(12), .RATE_W(2), .SUBCT_W(3), .CT_W(11)) dut (
    .clk(clk), .reset(reset), .rate_id(rate_id), .subchan_ct(subchan_ct),
    .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .perm_go(perm_go), .cfg_rate(cfg_rate), .cfg_subch(cfg_subch),
    .blk_ncbps(blk_ncbps), .rd_addr(rd_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .cfg_err(cfg_err), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [10:0] exp_q[$];
  logic [10:0] wr_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: Ncbps = base[rate] >> sub, words = Ncbps/12 (min 1).
  function automatic int model_ncbps(input int rate, input int sub);
    int base[4];
    base = '{192, 384, 768, 1152};
    return base[rate] >> sub;
  endfunction

  function automatic int model_words(input int rate, input int sub);
    int w;
    w = model_ncbps(rate, sub) / 12;
    return (w == 0) ? 1 : w;
  endfunction

  // ---------------- driver tasks ----------------
  // Fills one block. reset_at >= 0 asserts reset while word reset_at is
  // being offered and returns with aborted = 1.
  task automatic fill_block(input int rate, input int sub, input bit bubbles,
                            input int reset_at, output bit aborted);
    int w;
    int idx;
    int guard;
    logic [10:0] exp_wr;
    w = model_words(rate, sub);
    idx = 0;
    guard = 0;
    aborted = 1'b0;
    wr_q.delete();
    for (int i = 0; i < w; i++) wr_q.push_back(11'(i));
    while (idx < w && guard < 4 * w + 10) begin
      guard++;
      @(negedge clk);
      if (bubbles && idx > 0 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        #1;
        check("fill_bubble_wr_en", wr_en, 0);
        check("fill_bubble_in_ready", in_ready, 1);
        continue;
      end
      in_valid = 1'b1;
      if (idx == 0) begin
        rate_id = rate[1:0];
        subchan_ct = sub[2:0];
      end else begin
        // Config inputs must be ignored once the block has started.
        rate_id = 2'($urandom_range(0, 3));
        subchan_ct = 3'($urandom_range(0, 7));
      end
      if (idx == reset_at) reset = 1'b1;
      #1;
      exp_wr = wr_q.pop_front();
      check("fill_in_ready", in_ready, 1);
      check("fill_wr_en", wr_en, 1);
      check("fill_wr_addr", wr_addr, exp_wr);
      check("fill_out_valid", out_valid, 0);
      if (idx == 0) begin
        check("start_busy", busy, 0);
        check("start_cfg_err", cfg_err, 0);
      end else begin
        check("fill_busy", busy, 1);
        check("fill_cfg_rate", cfg_rate, rate);
        check("fill_cfg_subch", cfg_subch, sub);
      end
      if (idx == reset_at) begin
        @(negedge clk);
        in_valid = 1'b0;
        subchan_ct = 3'd0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_state", dbg_state, 0);
        check("abort_perm_go", perm_go, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_ncbps", blk_ncbps, 0);
        reset = 1'b0;
        aborted = 1'b1;
        return;
      end
      idx++;
    end
    check("fill_words_done", idx, w);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("perm_go", perm_go, 1);
    check("perm_state", dbg_state, 2);
    check("perm_in_ready", in_ready, 0);
    check("perm_out_valid", out_valid, 0);
    check("perm_cfg_rate", cfg_rate, rate);
    check("perm_cfg_subch", cfg_subch, sub);
    check("perm_ncbps", blk_ncbps, model_ncbps(rate, sub));
  endtask

  // mode 0: out_ready always 1; 1: random; 2: pattern 1,0,0,1 then 1.
  task automatic drain_block(input int rate, input int sub, input int mode);
    int w;
    int cyc;
    w = model_words(rate, sub);
    exp_q.delete();
    for (int i = 0; i < w; i++) exp_q.push_back(11'(i));
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 4 * w + 10) begin
      @(negedge clk);
      case (mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: out_ready = (cyc == 1 || cyc == 2) ? 1'b0 : 1'b1;
        default: out_ready = 1'b1;
      endcase
      #1;
      check("drain_out_valid", out_valid, 1);
      check("drain_rd_addr", rd_addr, exp_q[0]);
      check("drain_out_last", out_last, (exp_q[0] == 11'(w - 1)));
      check("drain_perm_go", perm_go, 0);
      check("drain_in_ready", in_ready, 0);
      if (out_ready) void'(exp_q.pop_front());
      cyc++;
    end
    check("drain_words_left", exp_q.size(), 0);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("post_drain_busy", busy, 0);
    check("post_drain_out_valid", out_valid, 0);
    check("post_drain_rd_addr", rd_addr, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit ab;
    reset = 1'b1;
    rate_id = 2'd0;
    subchan_ct = 3'd0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_perm_go", perm_go, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_ncbps", blk_ncbps, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_rd_addr", rd_addr, 0);

    // QPSK, 8 subchannels: Ncbps 192, 16 words.
    fill_block(1, 1, 1'b0, -1, ab);
    drain_block(1, 1, 0);

    // BPSK, 1 subchannel: single-word block.
    fill_block(0, 4, 1'b0, -1, ab);
    drain_block(0, 4, 0);

    // Downstream stall pattern 1,0,0,1.
    fill_block(2, 3, 1'b0, -1, ab);
    drain_block(2, 3, 2);

    // Illegal subchannel code is refused in IDLE.
    @(negedge clk);
    rate_id = 2'd2;
    subchan_ct = 3'd5;
    in_valid = 1'b1;
    #1;
    check("illegal_cfg_err", cfg_err, 1);
    check("illegal_in_ready", in_ready, 0);
    check("illegal_wr_en", wr_en, 0);
    check("illegal_busy", busy, 0);
    @(negedge clk);
    #1;
    check("illegal_stays_idle", busy, 0);
    fill_block(2, 2, 1'b0, -1, ab);
    drain_block(2, 2, 0);

    // 64-QAM, 16 subchannels; reset during the 7th FILL word.
    fill_block(3, 0, 1'b0, 7, ab);
    check("abort_flag", ab, 1);
    fill_block(3, 0, 1'b0, -1, ab);
    drain_block(3, 0, 1);

    // Random legal configurations with bubbles and stalls.
    for (int k = 0; k < 5; k++) begin
      int r;
      int s;
      r = $urandom_range(0, 3);
      s = $urandom_range(0, 4);
      fill_block(r, s, 1'b1, -1, ab);
      drain_block(r, s, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

endmodule
